// File: rtl/irda_fast_pkg.sv
// irda_fast_pkg
//   Shared definitions for the MIR/FIR fast-link controller: mode and state
//   encodings, the default CDR width and the reset CDR helper.
`ifndef IRDA_F_CDR_WIDTH
`define IRDA_F_CDR_WIDTH 24
`endif

package irda_fast_pkg;

  localparam int IRDA_F_CDR_WIDTH = `IRDA_F_CDR_WIDTH;

  typedef enum logic [1:0] {
    IRDA_MODE_OFF      = 2'b00,
    IRDA_MODE_MIR      = 2'b01,
    IRDA_MODE_MIR_HALF = 2'b10,
    IRDA_MODE_FIR      = 2'b11
  } irda_mode_e;

  typedef enum logic [2:0] {
    ST_RX      = 3'd0,
    ST_RELOAD  = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_TURN_TX = 3'd3,
    ST_TX      = 3'd4,
    ST_TURN_RX = 3'd5
  } irda_state_e;

  // CDR value loaded at reset: the bus clock divided down to the 40 MHz
  // reference, scaled by the fixed-point multiplier.
  function automatic longint irda_rst_cdr(input int bus_clock, input int mult);
    return longint'(bus_clock / 40) * longint'(mult);
  endfunction

endpackage

// File: rtl/irda_delay_timer.sv
// irda_delay_timer
//   Loadable saturating down-counter shared by the turnaround and settle
//   delays. A phase loaded with N lasts N cycles: done is high while the
//   count is 1 (or 0), i.e. in the last cycle of the phase.
// Ports:
//   clk, wb_rst_i  clock, async active-high reset
//   load           load load_val this cycle
//   load_val       delay length in cycles
//   done           last cycle of the loaded delay
module irda_delay_timer #(
  parameter int TMR_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 wb_rst_i,
  input  logic                 load,
  input  logic [TMR_WIDTH-1:0] load_val,
  output logic                 done
);

  logic [TMR_WIDTH-1:0] count;

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i)             count <= '0;
    else if (load)            count <= load_val;
    else if (count != '0)     count <= count - TMR_WIDTH'(1);
  end

  assign done = (count <= TMR_WIDTH'(1));

endmodule

// File: rtl/irda_fast_link_ctrl.sv
// irda_fast_link_ctrl
//   Sequences the MIR/FIR fast enable generator and owns the half-duplex
//   direction. Configuration writes are held pending and applied from RX
//   (reload strobe + settle hold); the transmitter is granted the medium
//   after a programmable turnaround gap and released through a second gap
//   that blanks the receiver against echo.
// Ports:
//   clk, wb_rst_i        clock, async active-high reset
//   cfg_write/mode/cdr   configuration write strobe and payload
//   loopback_enable      forces zero-length turnarounds
//   tx_req, tx_done      transmitter frame request (level) / end strobe
//   rx_busy              receiver inside a frame
//   f_cdr, en_reload, mir_mode, mir_half, fir_mode  enable generator config
//   tx_select, tx_grant  direction and transmit permission
//   cfg_busy             configuration pending or being applied
module irda_fast_link_ctrl
  import irda_fast_pkg::*;
#(
  parameter int MULT          = 100000,
  parameter int CDR_WIDTH     = `IRDA_F_CDR_WIDTH,
  parameter int BUS_CLOCK     = 200,
  parameter int TURN_CYCLES   = 8,
  parameter int SETTLE_CYCLES = 16,
  parameter int TMR_WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 wb_rst_i,
  input  logic                 cfg_write,
  input  logic [1:0]           cfg_mode,
  input  logic [CDR_WIDTH-1:0] cfg_cdr,
  input  logic                 loopback_enable,
  input  logic                 tx_req,
  input  logic                 tx_done,
  input  logic                 rx_busy,
  output logic [CDR_WIDTH-1:0] f_cdr,
  output logic                 en_reload,
  output logic                 mir_mode,
  output logic                 mir_half,
  output logic                 fir_mode,
  output logic                 tx_select,
  output logic                 tx_grant,
  output logic                 cfg_busy
);

  localparam logic [CDR_WIDTH-1:0] RST_CDR   = CDR_WIDTH'(irda_rst_cdr(BUS_CLOCK, MULT));
  localparam logic [TMR_WIDTH-1:0] TURN_VAL   = TMR_WIDTH'(TURN_CYCLES);
  localparam logic [TMR_WIDTH-1:0] SETTLE_VAL = TMR_WIDTH'(SETTLE_CYCLES);

  irda_state_e          state, nxt;
  irda_mode_e           mode_q, pend_mode, apply_mode;
  logic                 pend_valid, pend_nxt;
  logic [CDR_WIDTH-1:0] pend_cdr, apply_cdr;
  logic                 apply;
  logic                 tmr_load, tmr_done;
  logic [TMR_WIDTH-1:0] tmr_val;
  logic                 turn_zero;

  irda_delay_timer #(.TMR_WIDTH(TMR_WIDTH)) u_tmr (
    .clk      (clk),
    .wb_rst_i (wb_rst_i),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  assign turn_zero = (TURN_CYCLES == 0) || loopback_enable;

  // A write in the same cycle as the apply wins over the older pending value.
  assign apply_mode = cfg_write ? irda_mode_e'(cfg_mode) : pend_mode;
  assign apply_cdr  = cfg_write ? cfg_cdr : pend_cdr;

  always_comb begin
    nxt      = state;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state)
      ST_RX: begin
        if (!rx_busy && (pend_valid || cfg_write)) begin
          nxt = ST_RELOAD;
        end else if (!rx_busy && tx_req && mode_q != IRDA_MODE_OFF) begin
          if (turn_zero) nxt = ST_TX;
          else begin
            nxt      = ST_TURN_TX;
            tmr_load = 1'b1;
            tmr_val  = TURN_VAL;
          end
        end
      end
      ST_RELOAD: begin
        if (SETTLE_CYCLES == 0) nxt = ST_RX;
        else begin
          nxt      = ST_SETTLE;
          tmr_load = 1'b1;
          tmr_val  = SETTLE_VAL;
        end
      end
      ST_SETTLE:  if (tmr_done) nxt = ST_RX;
      ST_TURN_TX: begin
        // Losing the request aborts the turnaround before any grant.
        if (!tx_req)       nxt = ST_RX;
        else if (tmr_done) nxt = ST_TX;
      end
      ST_TX: begin
        if (tx_done) begin
          if (turn_zero) nxt = ST_RX;
          else begin
            nxt      = ST_TURN_RX;
            tmr_load = 1'b1;
            tmr_val  = TURN_VAL;
          end
        end
      end
      ST_TURN_RX: if (tmr_done) nxt = ST_RX;
      default:    nxt = ST_RX;
    endcase
  end

  assign apply    = (state == ST_RX) && (nxt == ST_RELOAD);
  assign pend_nxt = apply ? 1'b0 : (cfg_write || pend_valid);

  // Outputs are registered from the next state so they change on the edge
  // that enters each state.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= ST_RX;
      mode_q     <= IRDA_MODE_OFF;
      pend_valid <= 1'b0;
      pend_mode  <= IRDA_MODE_OFF;
      pend_cdr   <= '0;
      f_cdr      <= RST_CDR;
      en_reload  <= 1'b0;
      mir_mode   <= 1'b0;
      mir_half   <= 1'b0;
      fir_mode   <= 1'b0;
      tx_select  <= 1'b0;
      tx_grant   <= 1'b0;
      cfg_busy   <= 1'b0;
    end else begin
      state      <= nxt;
      pend_valid <= pend_nxt;
      if (!apply && cfg_write) begin
        pend_mode <= irda_mode_e'(cfg_mode);
        pend_cdr  <= cfg_cdr;
      end
      if (apply) begin
        mode_q   <= apply_mode;
        f_cdr    <= apply_cdr;
        mir_mode <= (apply_mode == IRDA_MODE_MIR) || (apply_mode == IRDA_MODE_MIR_HALF);
        mir_half <= (apply_mode == IRDA_MODE_MIR_HALF);
        fir_mode <= (apply_mode == IRDA_MODE_FIR);
      end
      en_reload <= (nxt == ST_RELOAD);
      tx_select <= (nxt == ST_TURN_TX) || (nxt == ST_TX) || (nxt == ST_TURN_RX);
      tx_grant  <= (nxt == ST_TX);
      cfg_busy  <= pend_nxt || (nxt == ST_RELOAD) || (nxt == ST_SETTLE);
    end
  end

endmodule
